uart_rx_deframer: RTL and testbench

- Receive-side consumer of the baud-rate generator's oversampling tick.
- Synchronises the serial rx line and detects a start bit. Majority-samples each bit at mid-bit, deserialises LSB-first and checks the stop bit.
- Presents each received word on a valid/ready output register to the downstream FIFO or bus interface.
- Reports framing and overrun errors as single-clock pulses.

---
 rtl/uart_rx_deframer.sv | 143 ++++++++++++++
 tb/tb_uart_rx_deframer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receive deframer with 3-sample majority vote at mid-bit and a valid/ready output register.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_deframer #(
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLING = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);
    localparam int CW = $clog2(OVERSAMPLING);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLING / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLING - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t POST_DATA = PARITY;
`else
    localparam state_t POST_DATA = STOP;
`endif

    state_t state, state_n;
    logic [1:0] sync;
    logic [2:0] hist;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DATA_BITS-1:0] shreg;
    logic rx_s, bit_val, at_mid, done_ok, done_bad, load;

    assign rx_s = sync[1];
    assign bit_val = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

    // state register
    always_ff @(posedge clock) state <= nreset ? state_n : IDLE;

    // next state: every transition waits for a sample tick
    always_comb begin
        state_n = state;
        if (sample_tick)
            case (state)
                IDLE:    state_n = rx_s ? IDLE : START;
                START:   state_n = (cnt != HALF) ? START : (bit_val ? IDLE : DATA);
                DATA:    state_n = (cnt == LAST && idx == IDX_LAST) ? POST_DATA : DATA;
`ifdef UART_RX_PARITY_EN
                PARITY:  state_n = (cnt == LAST) ? STOP : PARITY;
`endif
                STOP:    state_n = (cnt != LAST) ? STOP : (bit_val ? IDLE : BRK);
                BRK:     state_n = rx_s ? IDLE : BRK;
                default: state_n = IDLE;
            endcase
    end

    // outputs and stop-bit outcome decoded from the current state
    always_comb begin
        busy = state != IDLE;
        at_mid = sample_tick && cnt == LAST;
        done_ok = at_mid && state == STOP && bit_val;
        done_bad = at_mid && state == STOP && !bit_val;
        load = done_ok && (!rx_valid || rx_ready);
    end

    // synchroniser, sample history, bit counters and deserialiser
    always_ff @(posedge clock) begin
        if (!nreset) begin
            sync <= 2'b11;
            hist <= 3'b111;
            cnt <= '0;
            idx <= '0;
            shreg <= '0;
        end else begin
            sync <= {sync[0], rx};
            if (sample_tick) begin
                hist <= {hist[1:0], rx_s};
                cnt <= (state_n != state || cnt == LAST || state == IDLE || state == BRK) ? '0 : cnt + 1'b1;
                idx <= (state != DATA) ? '0 : (cnt == LAST) ? idx + 1'b1 : idx;
                if (state == DATA && cnt == LAST)
                    shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad, pe_q;

    // latch parity check result at the parity bit centre
    always_ff @(posedge clock) begin
        if (!nreset)
            par_bad <= 1'b0;
        else if (sample_tick && state == PARITY && cnt == LAST)
            par_bad <= bit_val != (^shreg ^ (PARITY_ODD != 0));
    end

    // parity error pulses alongside the delivered word
    always_ff @(posedge clock) pe_q <= nreset && load && par_bad;

    assign parity_err = pe_q;
`else
    logic unused_cfg;

    assign unused_cfg = PARITY_ODD != 0;
    assign parity_err = 1'b0;
`endif

    // output register with valid/ready handshake and error pulses
    always_ff @(posedge clock) begin
        if (!nreset) begin
            rx_data <= '0;
            rx_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            frame_err <= done_bad;
            overrun <= done_ok && rx_valid && !rx_ready;
            if (load) begin
                rx_data <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed and randomized self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;
    localparam int BIT = 32;
    localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic nreset = 1'b0;
    logic rx = 1'b1;
    logic rx_ready = 1'b0;
    logic sample_tick;
    logic [7:0] rx_data;
    logic rx_valid, busy, frame_err, overrun, parity_err;
    logic [1:0] tdiv = 2'd0;
    int total = 0;
    int bad = 0;
    int n_fe = 0, n_ovr = 0, n_pe = 0, n_rise = 0, n_vhigh = 0;
    logic pv = 1'b0, pb = 1'b0, rise_pe = 1'b0;
    logic [1:0] rise_busy = 2'b00;
    logic [7:0] got[$];

    uart_rx_deframer dut (
        .clock(clock),
        .nreset(nreset),
        .sample_tick(sample_tick),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .busy(busy),
        .frame_err(frame_err),
        .overrun(overrun),
        .parity_err(parity_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) tdiv <= tdiv + 2'd1;

    assign sample_tick = (tdiv == 2'd0);

    always @(negedge clock) begin
        if (rx_valid && rx_ready) got.push_back(rx_data);
        n_fe += int'(frame_err);
        n_ovr += int'(overrun);
        n_pe += int'(parity_err);
        n_vhigh += int'(rx_valid);
        if (rx_valid && !pv) begin
            n_rise++;
            rise_busy = {pb, busy};
            rise_pe = parity_err;
        end
        pv = rx_valid;
        pb = busy;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pop_got();
        return got.size() > 0 ? int'(got.pop_front()) : -1;
    endfunction

    task automatic align();
        do step(1); while (tdiv != 2'd0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input bit rdy_pulse, input int rst_bit);
        logic [10:0] bits;
        int nb;
        bits = PAR_EN ? {stop, par, d, 1'b0} : {1'b0, stop, d, 1'b0};
        nb = PAR_EN ? 11 : 10;
        align();
        for (int j = 0; j < nb; j++) begin
            rx = bits[j];
            if (j == nb - 1 && rdy_pulse) begin
                step(20);
                rx_ready = 1'b1;
                step(1);
                rx_ready = 1'b0;
                step(BIT - 21);
            end else if (j == rst_bit) begin
                step(16);
                nreset = 1'b0;
                step(1);
                nreset = 1'b1;
                check("rst_valid", rx_valid, 0);
                check("rst_data", rx_data, 0);
                check("rst_busy", busy, 0);
                check("rst_pulses", {frame_err, overrun, parity_err}, 0);
                step(BIT - 17);
            end else begin
                step(BIT);
            end
        end
    endtask

    task automatic send_ok(input logic [7:0] d);
        send_frame(d, 1'b1, ^d ^ PODD, 1'b0, -1);
        rx = 1'b1;
        step(40);
    endtask

    initial begin
        int r0, vh0;
        logic [7:0] r;
        step(3);
        check("reset_out", {rx_data, rx_valid, busy}, 0);
        check("reset_pulses", {frame_err, overrun, parity_err}, 0);
        nreset = 1'b1;
        step(40);
        check("idle_busy", busy, 0);

        rx_ready = 1'b1;
        vh0 = n_vhigh;
        send_ok(8'hA5);
        check("basic_data", pop_got(), 8'hA5);
        check("basic_vhigh", n_vhigh - vh0, 1);
        check("basic_busy_fall", rise_busy, 2'b10);
        check("basic_err", n_fe + n_ovr + n_pe, 0);

        r0 = n_rise;
        align();
        rx = 1'b0;
        step(8);
        rx = 1'b1;
        step(80);
        check("glitch_rise", n_rise - r0, 0);
        check("glitch_fe", n_fe, 0);
        check("glitch_busy", busy, 0);

        r = 8'h3C;
        send_frame(r, 1'b0, ^r ^ PODD, 1'b0, -1);
        step(3 * 10 * BIT);
        check("break_busy", busy, 1);
        rx = 1'b1;
        step(40);
        check("break_fe", n_fe, 1);
        check("break_rise", n_rise - r0, 0);
        send_ok(8'h81);
        check("after_break", pop_got(), 8'h81);
        check("after_break_fe", n_fe, 1);

        rx_ready = 1'b0;
        r0 = n_rise;
        send_ok(8'h11);
        send_ok(8'h22);
        check("ovr_count", n_ovr, 1);
        check("ovr_hold", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        check("ovr_nogot", got.size(), 0);
        r = 8'h33;
        send_frame(r, 1'b1, ^r ^ PODD, 1'b1, -1);
        rx = 1'b1;
        step(40);
        check("accept_old", pop_got(), 8'h11);
        check("accept_new", rx_data, 8'h33);
        check("accept_valid", rx_valid, 1);
        check("accept_ovr", n_ovr, 1);
        check("accept_rise", n_rise - r0, 1);

        r = 8'hFF;
        send_frame(r, 1'b1, ^r ^ PODD, 1'b0, 5);
        rx = 1'b1;
        step(40);
        check("rst_after_valid", rx_valid, 0);
        check("rst_after_got", got.size(), 0);
        check("rst_after_fe", n_fe, 1);
        rx_ready = 1'b1;
        send_ok(8'h5A);
        check("rst_next", pop_got(), 8'h5A);
        check("rst_next_err", n_fe * 16 + n_ovr, 16 + 1);

`ifdef UART_RX_PARITY_EN
        r = 8'h07;
        send_frame(r, 1'b1, 1'b1, 1'b0, -1);
        rx = 1'b1;
        step(40);
        check("par_good", pop_got(), 8'h07);
        check("par_good_pe", n_pe, 0);
        send_frame(r, 1'b1, 1'b0, 1'b0, -1);
        rx = 1'b1;
        step(40);
        check("par_bad", pop_got(), 8'h07);
        check("par_bad_pe", n_pe, 1);
        check("par_bad_at_rise", rise_pe, 1);
`endif

        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom);
            send_ok(r);
            check("rand_word", pop_got(), int'(r));
        end
        check("final_pe", n_pe, PAR_EN ? 1 : 0);
        check("final_ovr", n_ovr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
